lpc_host: RTL and testbench

LPC_HOST -- requirements
Module: lpc_host

---
 rtl/lpc_host.sv | 206 ++++++++++++++++++++
 tb/tb_lpc_host.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_host.sv
// LPC host cycle engine: I/O and memory read/write over LAD/LFRAME#.
// Define LPC_HOST_SYNC_TIMEOUT_EN to enable the SYNC-wait timeout abort.
module lpc_host #(
  parameter int TIMEOUT = 64
) (
  input  logic        lpc_clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cyctype_dir,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_error,
  output logic [3:0]  lpc_ad_out,
  output logic        lpc_ad_oe,
  input  logic [3:0]  lpc_ad_in,
  output logic        lpc_frame
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, START, CYCDIR, ADDR, WDATA,
    TAR_H, SYNC, RDATA, TAR_P, ABORT
  } state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic [WW-1:0] wait_q;
  logic [3:0]    cyc_q;
  logic [31:0]   addr_q;
  logic [7:0]    wdata_q;
  logic          err_q;
  logic [7:0]    rdata_q;
  logic          rvalid_q;
  logic          rerr_q;
  logic          frame_q;
  logic          oe_q;
  logic [3:0]    ad_q;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = rvalid_q;
  assign resp_error = rerr_q;
  assign resp_rdata = rdata_q;
  assign lpc_frame  = frame_q;
  assign lpc_ad_oe  = oe_q;
  assign lpc_ad_out = ad_q;

  // Outputs are registered: each transition loads the
  // bus values belonging to the state being entered.
  always_ff @(posedge lpc_clock) begin
    rvalid_q <= 1'b0;
    rerr_q   <= 1'b0;
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      cyc_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
      frame_q <= 1'b1;
      oe_q    <= 1'b0;
      ad_q    <= 4'hF;
    end else begin
      unique case (state_q)
        IDLE: begin
          frame_q <= 1'b1;
          oe_q    <= 1'b0;
          ad_q    <= 4'hF;
          if (req_valid) begin
            cyc_q   <= req_cyctype_dir;
            wdata_q <= req_wdata;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            // I/O addresses are left-aligned so the shifter
            // always emits bits [31:28] next.
            addr_q  <= req_cyctype_dir[2] ? req_addr
                                          : {req_addr[15:0], 16'h0};
            if (req_cyctype_dir[3]) begin
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
            end else begin
              state_q <= START;
              frame_q <= 1'b0;
              oe_q    <= 1'b1;
              ad_q    <= 4'h0;
            end
          end
        end
        START: begin
          state_q <= CYCDIR;
          frame_q <= 1'b1;
          ad_q    <= cyc_q;
        end
        CYCDIR: begin
          state_q <= ADDR;
          ad_q    <= addr_q[31:28];
          addr_q  <= addr_q << 4;
        end
        ADDR: begin
          if (cnt_q == (cyc_q[2] ? 3'd7 : 3'd3)) begin
            cnt_q <= '0;
            if (cyc_q[1]) begin
              state_q <= WDATA;
              ad_q    <= wdata_q[3:0];
            end else begin
              state_q <= TAR_H;
              ad_q    <= 4'hF;
            end
          end else begin
            cnt_q  <= cnt_q + 3'd1;
            ad_q   <= addr_q[31:28];
            addr_q <= addr_q << 4;
          end
        end
        WDATA: begin
          if (cnt_q == 3'd0) begin
            cnt_q <= 3'd1;
            ad_q  <= wdata_q[7:4];
          end else begin
            cnt_q   <= '0;
            state_q <= TAR_H;
            ad_q    <= 4'hF;
          end
        end
        TAR_H: begin
          if (cnt_q == 3'd0) begin
            cnt_q <= 3'd1;
            oe_q  <= 1'b0;
          end else begin
            cnt_q   <= '0;
            wait_q  <= '0;
            state_q <= SYNC;
          end
        end
        SYNC: begin
          unique case (1'b1)
            (lpc_ad_in == 4'b0000):
              state_q <= cyc_q[1] ? TAR_P : RDATA;
            (lpc_ad_in == 4'b1010): begin
              err_q   <= 1'b1;
              state_q <= TAR_P;
            end
            default: begin
              if (wait_q != WW'(TIMEOUT)) wait_q <= wait_q + 1'b1;
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
              if (wait_q == WW'(TIMEOUT - 1)) begin
                state_q <= ABORT;
                cnt_q   <= '0;
                frame_q <= 1'b0;
                oe_q    <= 1'b1;
                ad_q    <= 4'hF;
              end
`endif
            end
          endcase
        end
        RDATA: begin
          if (cnt_q == 3'd0) begin
            cnt_q        <= 3'd1;
            rdata_q[3:0] <= lpc_ad_in;
          end else begin
            cnt_q        <= '0;
            rdata_q[7:4] <= lpc_ad_in;
            state_q      <= TAR_P;
          end
        end
        TAR_P: begin
          if (cnt_q == 3'd0) begin
            cnt_q    <= 3'd1;
            rvalid_q <= 1'b1;
            rerr_q   <= err_q;
          end else begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        ABORT: begin
`ifdef LPC_HOST_SYNC_TIMEOUT_EN
          // Four LFRAME# low clocks, then one bus-idle clock.
          if (cnt_q == 3'd4) begin
            cnt_q    <= '0;
            state_q  <= IDLE;
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              frame_q <= 1'b1;
              oe_q    <= 1'b0;
            end
          end
`else
          state_q <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Directed, table-driven bench for lpc_host.
// Build with LPC_HOST_SYNC_TIMEOUT_EN to also exercise the abort path.
module tb_lpc_host;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cyctype_dir;
  logic [31:0] req_addr;
  logic [7:0]  req_wdata;
  logic        resp_valid;
  logic [7:0]  resp_rdata;
  logic        resp_error;
  logic [3:0]  lpc_ad_out;
  logic        lpc_ad_oe;
  logic [3:0]  lpc_ad_in;
  logic        lpc_frame;

  always #5 clk = ~clk;

`ifdef LPC_HOST_SYNC_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  lpc_host #(.TIMEOUT(TMO)) dut (
    .lpc_clock      (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cyctype_dir(req_cyctype_dir),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .lpc_ad_out     (lpc_ad_out),
    .lpc_ad_oe      (lpc_ad_oe),
    .lpc_ad_in      (lpc_ad_in),
    .lpc_frame      (lpc_frame)
  );

  typedef struct {
    logic [3:0]  cyc;
    logic [31:0] addr;
    logic [7:0]  wd;
    int          nwait;
    bit          serr;
    logic [7:0]  rd;
    logic [7:0]  exp_rd;
    bit          exp_err;
    int          exp_clk;
  } vec_t;

  vec_t tbl[7];
  int   errors = 0;
  int   checks = 0;
  logic [5:0] exp_q[$];
  logic [3:0] drv_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] wcode(input int i);
    logic [3:0] c[3];
    c[0] = 4'b0101;
    c[1] = 4'b0110;
    c[2] = 4'b0011;
    return c[i % 3];
  endfunction

  // Builds the expected per-clock bus schedule, then runs the cycle.
  task automatic run(input int idx, input vec_t v);
    int n;
    bit done;
    logic [5:0] e;
    logic [5:0] a;
    exp_q.delete();
    drv_q.delete();
    exp_q.push_back({2'b01, 4'h0});  drv_q.push_back(4'hF);
    exp_q.push_back({2'b11, v.cyc}); drv_q.push_back(4'hF);
    n = v.cyc[2] ? 8 : 4;
    for (int i = n - 1; i >= 0; i--) begin
      exp_q.push_back({2'b11, v.addr[4*i +: 4]});
      drv_q.push_back(4'hF);
    end
    if (v.cyc[1]) begin
      exp_q.push_back({2'b11, v.wd[3:0]}); drv_q.push_back(4'hF);
      exp_q.push_back({2'b11, v.wd[7:4]}); drv_q.push_back(4'hF);
    end
    exp_q.push_back({2'b11, 4'hF}); drv_q.push_back(4'hF);
    exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(4'hF);
    for (int i = 0; i < v.nwait; i++) begin
      exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(wcode(i));
    end
    exp_q.push_back({2'b10, 4'hF});
    drv_q.push_back(v.serr ? 4'b1010 : 4'b0000);
    if (!v.cyc[1] && !v.serr) begin
      exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(v.rd[3:0]);
      exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(v.rd[7:4]);
    end
    exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(4'hF);
    exp_q.push_back({2'b10, 4'hF}); drv_q.push_back(4'hF);

    @(negedge clk);
    chk($sformatf("v%0d ready", idx), 32'(req_ready), 32'd1);
    req_valid       = 1'b1;
    req_cyctype_dir = v.cyc;
    req_addr        = v.addr;
    req_wdata       = v.wd;
    lpc_ad_in       = 4'hF;
    done = 1'b0;
    for (int k = 1; k <= exp_q.size() + 4 && !done; k++) begin
      @(negedge clk);
      // Busy: keep req_valid high with junk fields; must be ignored.
      req_cyctype_dir = 4'($urandom);
      req_addr        = $urandom;
      req_wdata       = 8'($urandom);
      e = (k <= exp_q.size()) ? exp_q[k-1] : {2'b10, 4'hF};
      if (!e[4]) e[3:0] = 4'hF;
      lpc_ad_in = (k <= drv_q.size()) ? drv_q[k-1] : 4'hF;
      a = {lpc_frame, lpc_ad_oe, lpc_ad_oe ? lpc_ad_out : 4'hF};
      chk($sformatf("v%0d bus clk%0d", idx, k), 32'(a), 32'(e));
      if (resp_valid) begin
        done = 1'b1;
        req_valid = 1'b0;
        chk($sformatf("v%0d resp clk", idx), k, v.exp_clk);
        chk($sformatf("v%0d rdata", idx), 32'(resp_rdata), 32'(v.exp_rd));
        chk($sformatf("v%0d error", idx), 32'(resp_error), 32'(v.exp_err));
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL v%0d timeout: got no resp_valid want pulse", idx);
    end
  endtask

  initial begin
    //        cyc    addr          wd    nw er rd     exp_rd er clk
    tbl[0] = '{4'h2, 32'h0000_0080, 8'hA5, 0, 0, 8'h00, 8'h00, 0, 13};
    tbl[1] = '{4'h0, 32'h0000_0060, 8'h00, 2, 0, 8'hC4, 8'hC4, 0, 15};
    tbl[2] = '{4'h4, 32'hFFFF_FFF0, 8'h00, 0, 0, 8'h3B, 8'h3B, 0, 17};
    tbl[3] = '{4'h0, 32'h0000_0070, 8'h00, 0, 1, 8'h99, 8'h3B, 1, 11};
    tbl[4] = '{4'h6, 32'h1234_5678, 8'h5A, 1, 0, 8'h00, 8'h3B, 0, 18};
    tbl[5] = '{4'h2, 32'h0000_0080, 8'h11, 0, 1, 8'h00, 8'h3B, 1, 13};
    tbl[6] = '{4'h0, 32'hABCD_03F8, 8'h00, 3, 0, 8'h7E, 8'h7E, 0, 16};

    reset = 1'b1;
    req_valid = 1'b0;
    req_cyctype_dir = 4'h0;
    req_addr = '0;
    req_wdata = '0;
    lpc_ad_in = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("rst outs",
        {lpc_frame, lpc_ad_oe, lpc_ad_out, req_ready, resp_valid, resp_error},
        {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0});
    chk("rst rdata", 32'(resp_rdata), 32'h00);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run(i, tbl[i]);

    // Unsupported cycle type: no bus activity, error pulse next clock.
    @(negedge clk);
    req_valid = 1'b1;
    req_cyctype_dir = 4'b1100;
    @(negedge clk);
    req_valid = 1'b0;
    chk("unsup resp",
        {resp_valid, resp_error, lpc_frame, lpc_ad_oe, resp_rdata},
        {1'b1, 1'b1, 1'b1, 1'b0, 8'h7E});
    @(negedge clk);
    chk("unsup pulse", 32'(resp_valid), 32'd0);

    // Reset during ADDR abandons the cycle silently.
    req_valid = 1'b1;
    req_cyctype_dir = 4'h0;
    req_addr = 32'h0000_1234;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid addr oe", 32'(lpc_ad_oe), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid rst outs",
        {lpc_frame, lpc_ad_oe, lpc_ad_out, req_ready, resp_valid, resp_rdata},
        {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 8'h00});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post rst idle%0d", i),
          {resp_valid, req_ready, lpc_frame}, {1'b0, 1'b1, 1'b1});
    end
    run(7, tbl[1]);

`ifdef LPC_HOST_SYNC_TIMEOUT_EN
    begin
      bit seen = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_cyctype_dir = 4'h0;
      req_addr = 32'h0000_0060;
      @(negedge clk);
      req_valid = 1'b0;
      lpc_ad_in = 4'b0110;
      for (int k = 1; k <= 18; k++) begin
        if (k > 1) @(negedge clk);
        if (k >= 9 && k <= 12)
          chk($sformatf("tmo sync clk%0d", k),
              {resp_valid, lpc_frame, lpc_ad_oe}, {1'b0, 1'b1, 1'b0});
        if (k >= 13 && k <= 16)
          chk($sformatf("tmo abort clk%0d", k),
              {resp_valid, lpc_frame, lpc_ad_oe, lpc_ad_out},
              {1'b0, 1'b0, 1'b1, 4'hF});
        if (k == 17)
          chk("tmo idle", {resp_valid, lpc_frame, lpc_ad_oe},
              {1'b0, 1'b1, 1'b0});
        if (k == 18) begin
          seen = 1'b1;
          chk("tmo resp", {resp_valid, resp_error}, {1'b1, 1'b1});
        end
      end
      lpc_ad_in = 4'hF;
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL tmo seq: got short loop want 18 clocks");
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
